// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the MUL/DIV sequencer and its ALU wrapper.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;

  localparam int ITER  = 16;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 16-bit ripple ALU: AND / OR / ADD, with Bnegate inverting B and feeding carry-in.
module ALU_16bit
  import alu_ctrl_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        Bnegate,
  input  logic [2:0]  Operation,
  output logic [15:0] Result,
  output logic        CarryOut
);

  logic [15:0] sum;
  logic [15:0] b_eff;
  logic        c;

  assign b_eff = b ^ {16{Bnegate}};

  always_comb begin
    sum = '0;
    c   = Bnegate;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ c;
      c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
    end
  end

  assign CarryOut = c;

  always_comb begin
    Result = '0;
    case (Operation)
      ALU_OP_AND: Result = a & b_eff;
      ALU_OP_OR:  Result = a | b_eff;
      ALU_OP_ADD: Result = sum;
      default:    Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq_unit.sv
// MUL/DIV unit: the sequencer closed around one ALU_16bit instance.
module alu_muldiv_unit
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_hi,
  output logic [15:0] res_lo,
  output logic        div_by_zero
);

  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_bnegate, alu_cout;
  logic [2:0]  alu_op;

  alu_muldiv_seq #(.WIDTH(16)) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .busy        (busy),
    .done        (done),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_bnegate (alu_bnegate),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  ALU_16bit u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .Bnegate   (alu_bnegate),
    .Operation (alu_op),
    .Result    (alu_result),
    .CarryOut  (alu_cout)
  );

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequencer turning one external 16-bit ALU into a shift-add MUL / restoring DIV unit.
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | 16 iterations, one ALU pass each
// FIN   | done pulse, results valid
module alu_muldiv_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             busy_q, done_q, dbz_q;

  logic             run, is_div, t17, success;
  logic [WIDTH-1:0] t;

  assign run     = (state_q == RUN);
  assign is_div  = (op_q == OP_DIV);
  // Divider trial value: {rem, q[msb]} is 17 bits; the top bit forces success.
  assign t17     = hi_q[WIDTH-1];
  assign t       = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign success = t17 | alu_cout;

  assign alu_a       = run ? (is_div ? t : hi_q) : '0;
  assign alu_b       = run ? opnd_q : '0;
  assign alu_bnegate = run & is_div;
  assign alu_op      = run ? ALU_OP_ADD : 3'b000;

  assign busy        = busy_q;
  assign done        = done_q;
  assign res_hi      = hi_q;
  assign res_lo      = lo_q;
  assign div_by_zero = dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            cnt_q  <= '0;
            busy_q <= 1'b1;
            opnd_q <= (op == OP_DIV) ? opb : opa;
            if (op == OP_DIV && opb == '0) begin
              hi_q    <= opa;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              hi_q    <= '0;
              lo_q    <= (op == OP_DIV) ? opa : opb;
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            hi_q <= success ? alu_result : t;
            lo_q <= {lo_q[WIDTH-2:0], success};
          end else if (lo_q[0]) begin
            {hi_q, lo_q} <= {alu_cout, alu_result, lo_q[WIDTH-1:1]};
          end else begin
            {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq, with a behavioural ALU and a parallel alu_muldiv_unit.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] opa = '0, opb = '0;

  logic        busy, done, dbz, alu_bnegate, alu_cout;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [16:0] alu_sum;

  logic        u_busy, u_done, u_dbz;
  logic [15:0] u_res_hi, u_res_lo;

  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b ^ {16{alu_bnegate}}} + {16'b0, alu_bnegate};
  assign alu_result = alu_sum[15:0];
  assign alu_cout   = alu_sum[16];

  alu_muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(dbz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  alu_muldiv_unit u_unit (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(u_busy), .done(u_done), .res_hi(u_res_hi), .res_lo(u_res_lo),
    .div_by_zero(u_dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        z;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("res_hi", 64'(res_hi), 64'(mon_e.hi));
        check("res_lo", 64'(res_lo), 64'(mon_e.lo));
        check("div_by_zero", 64'(dbz), 64'(mon_e.z));
        check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        check("busy_at_done", 64'(busy), 64'd1);
        check("unit_result", {30'b0, u_done, u_busy, u_res_hi, u_res_lo, u_dbz},
              {30'b0, 1'b1, 1'b1, mon_e.hi, mon_e.lo, mon_e.z});
      end
    end
  end

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
      sb.delete();
    end
  endtask

  // Caller is at a rising edge; start is raised 1 time unit later.
  task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] hi, input logic [15:0] lo, input logic z,
                       input int lat);
    exp_t e;
    #1;
    op = o; opa = a; opb = b; start = 1'b1;
    e.hi = hi; e.lo = lo; e.z = z; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty();
  endtask

  initial begin
    #2;
    check("reset_outputs", {29'b0, busy, done, res_hi, res_lo, dbz}, 64'd0);
    check("reset_alu", {28'b0, alu_a, alu_b, alu_bnegate, alu_op}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    do_op(1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 17);
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
    do_op(1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17);
    do_op(1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 17);
    do_op(1'b1, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 1'b0, 17);
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17);
    do_op(1'b1, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 17);
    do_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1);

    #1;
    check("dbz_held", {31'b0, dbz, res_hi, res_lo}, {31'b0, 1'b1, 16'h1234, 16'hFFFF});
    repeat (3) @(posedge clk);
    #1;
    check("dbz_held_later", {31'b0, dbz, res_hi, res_lo}, {31'b0, 1'b1, 16'h1234, 16'hFFFF});
    @(posedge clk);

    // New start in the middle of a MUL must be ignored.
    do_op(1'b0, 16'h0100, 16'h0300, 16'h0003, 16'h0000, 1'b0, 17);
    @(posedge clk);
    begin
      exp_t e;
      #1;
      op = 1'b0; opa = 16'h0100; opb = 16'h0300; start = 1'b1;
      e.hi = 16'h0003; e.lo = 16'h0000; e.z = 1'b0; e.lat = 17; e.t0 = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      op = 1'b1; opa = 16'h0009; opb = 16'h0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_empty();
      repeat (4) @(posedge clk);
    end

    // Reset at iteration 8 of a DIV aborts it with no done.
    #1;
    op = 1'b1; opa = 16'hFFFF; opb = 16'h0003; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("div_running", {60'b0, busy, alu_bnegate, alu_op[1:0]}, {60'b0, 1'b1, 1'b1, 2'b10});
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {29'b0, busy, done, res_hi, res_lo, dbz}, 64'd0);
    check("abort_alu", {28'b0, alu_a, alu_b, alu_bnegate, alu_op}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    do_op(1'b0, 16'd2, 16'd2, 16'h0000, 16'h0004, 1'b0, 17);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that runs unsigned 16×16 multiply and 16/16 divide on the shared 16-bit ripple ALU (ALU_16bit). It drives the ALU operand, Bnegate and Operation inputs each cycle and captures Result/CarryOut into its own shift registers. The block sits between the instruction decode/execute stage and the ALU, and turns one ALU into a MUL/DIV unit with a start/done handshake.

## Interface
- `WIDTH`, 16: operand width; only 16 is supported, because it matches the ALU.
- `clk`  in  1: single clock; rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; accepted only when `busy`=0.
- `op`  in  1: 0 = MUL, 1 = DIV; sampled with `start`.
- `opa`, `opb`  in  16 each: multiplicand/multiplier, or dividend/divisor; sampled with `start`.
- `busy`  out  1: high from the cycle after accept until `done`, inclusive.
- `done`  out  1: one-cycle pulse; the results are valid from this cycle on.
- `res_hi`, `res_lo`  out  16 each: MUL gives the product as {hi,lo}; DIV gives hi = remainder, lo = quotient.
- `div_by_zero`  out  1: valid with `done`; held until the next accept.
- `alu_a`, `alu_b`  out  16 each: ALU operands.
- `alu_bnegate`  out  1: ALU Bnegate, which is also the bit-0 carry-in.
- `alu_op`  out  3: ALU Operation.
- `alu_result`  in  16: ALU Result, combinational from `alu_a`/`alu_b` in the same cycle.
- `alu_cout`  in  1: ALU CarryOut.

## Operation
- States: IDLE, RUN, FIN.
  - IDLE with `start`: go to RUN and set the iteration counter `cnt` to 0. The DIV-by-zero case is the exception and is listed below.
  - RUN: go to FIN when `cnt`=15 completes.
  - FIN: go to IDLE.
- The ALU is always driven with `alu_op` = ALU_OP_ADD (3'b010).
  - `alu_bnegate`=1 only for the DIV trial subtract.
  - In IDLE and FIN the ALU outputs are 0 and `alu_bnegate`=0.
- MUL (shift-add), on accept:
  - Load `acc`=0, `mq`=`opb`, `md`=`opa`.
  - Each RUN cycle drives `alu_a`=`acc` and `alu_b`=`md`.
  - If `mq[0]`: {acc,mq} ← {alu_cout, alu_result, mq[15:1]}.
  - Otherwise: {acc,mq} ← {1'b0, acc, mq[15:1]}.
  - After 16 iterations, `res_hi`=`acc` and `res_lo`=`mq`.
- DIV (restoring), on accept:
  - Load `rem`=0, `q`=`opa`, `d`=`opb`.
  - Each RUN cycle forms {t17, t} = {rem, q[15]}, which is 17 bits.
  - Drive `alu_a`=t, `alu_b`=d, `alu_bnegate`=1, so the ALU computes t − d.
  - Success is `t17 | alu_cout`; a carry of 1 means no borrow.
  - On success: `rem` ← `alu_result`, q ← {q[14:0], 1}.
  - Otherwise: `rem` ← t, q ← {q[14:0], 0}.
  - After 16 iterations, `res_hi`=`rem` and `res_lo`=`q`.
- DIV with `opb`=0: skip RUN and go IDLE→FIN directly.
  - Results: `res_lo`=16'hFFFF, `res_hi`=`opa`, `div_by_zero`=1.
- `start` while `busy`: ignored, with no effect on state or results.
- `start` in FIN: ignored. The requester must reissue it in IDLE.
- Results and `div_by_zero` hold their values until the next accepted `start`.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `res_hi`=`res_lo`=0, `div_by_zero`=0, all `alu_*` outputs=0, `cnt`=0.
- Reset mid-operation aborts immediately (asynchronous). No `done` is produced for the aborted request.
- Latency:
  - `start` sampled at edge E0.
  - RUN occupies the cycles after E0 through E16, which is 16 iterations.
  - FIN (`done`=1) is the cycle after E16. MUL/DIV therefore have a start-to-done latency of 17 cycles.
  - Divide-by-zero latency is 1 cycle: `done` in the cycle after E0.
- Throughput: a new `start` is accepted at the earliest 1 cycle after `done`. That gives 18 cycles per operation back-to-back.
- The ALU path is combinational within a cycle: the ALU ripple delay plus the capture mux must fit in one clock period.

## Structure
- Package `alu_ctrl_pkg`:
  - ALU_OP_ADD = 3'b010.
  - OP_MUL/OP_DIV encodings.
  - The state enum {IDLE, RUN, FIN}.
  - ITER = 16.
- One wrapper sub-module, `alu_muldiv_unit`, instantiates `alu_muldiv_seq` plus ALU_16bit and wires them together. The sequencer itself contains no ALU.
- The sequencer keeps one shared 16-bit hi register (`acc`/`rem`), one shared lo register (`mq`/`q`) and one operand register (`md`/`d`).

## Test plan
- MUL `opa`=3, `opb`=5 → `done` 17 cycles after `start`; `res_hi`=0x0000, `res_lo`=0x000F.
- MUL 0xFFFF × 0xFFFF → `res_hi`=0xFFFE, `res_lo`=0x0001. This exercises the carry into `acc`.
- DIV 100 / 7 → `res_lo`=14, `res_hi`=2. DIV 0x8000 / 0x0001 → `res_lo`=0x8000, `res_hi`=0. DIV 0xFFFF / 0xFFFF → `res_lo`=1, `res_hi`=0.
- DIV 0x1234 / 0 → `done` 1 cycle after `start`; `div_by_zero`=1, `res_lo`=0xFFFF, `res_hi`=0x1234.
- Pulse `start` at cycle 5 of a MUL with new operands → ignored; the original product is returned and exactly one `done` occurs.
- Assert `rst_n`=0 at iteration 8 of a DIV → all outputs 0 immediately. After release, a new MUL 2×2 → `res_lo`=4.
